switch_allocator: RTL and testbench

- Per-router control block that drains the five input queues (N, S, E, W, L) into the crossbar.
- Computes the XY-route output for each queue head.
- Runs one round-robin arbiter per output port.
- Issues registered one-cycle pop requests to the queues and crossbar select/valid to the output side.

---
 rtl/switch_allocator_pkg.sv | 27 ++
 rtl/switch_allocator_if.sv | 39 +++
 rtl/switch_allocator_rr_arbiter5.sv | 101 ++++++++++
 rtl/switch_allocator.sv | 103 ++++++++++
 tb/tb_switch_allocator.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/switch_allocator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared types and constants for the router switch allocator.
//               Port indices, select width and the round-robin step helper.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

  localparam int NUM_PORTS = 5;
  localparam int SEL_W     = 3;

  typedef logic [SEL_W-1:0] port_t;

  localparam port_t PORT_N = 3'd0;
  localparam port_t PORT_S = 3'd1;
  localparam port_t PORT_E = 3'd2;
  localparam port_t PORT_W = 3'd3;
  localparam port_t PORT_L = 3'd4;

  // Index reached by stepping 'step' places past 'base' around the ring of ports.
  function automatic port_t rr_next(port_t base, int step);
    return port_t'((int'(base) + step) % NUM_PORTS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_allocator_if.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator_if
// Description : Queue-side and crossbar-side signals of the switch allocator.
//   valid_i/dest_x_i/dest_y_i/tail_i : input-queue head status
//   out_ready_i                      : output port can accept a flit
//   pop_req_o                        : one-cycle pop strobe per input queue
//   sel_o/out_valid_o                : crossbar select and valid per output
//   master : environment side (drives queue heads, readies)
//   slave  : allocator side
// Revision    : 1.0 - initial release
// ============================================================================
interface switch_allocator_if
  import noc_pkg::*;
#(
  parameter int COORD_W = 2
);

  logic [NUM_PORTS-1:0]         valid_i;
  logic [NUM_PORTS*COORD_W-1:0] dest_x_i;
  logic [NUM_PORTS*COORD_W-1:0] dest_y_i;
  logic [NUM_PORTS-1:0]         tail_i;
  logic [NUM_PORTS-1:0]         out_ready_i;
  logic [NUM_PORTS-1:0]         pop_req_o;
  logic [NUM_PORTS*SEL_W-1:0]   sel_o;
  logic [NUM_PORTS-1:0]         out_valid_o;

  modport master (
    output valid_i, dest_x_i, dest_y_i, tail_i, out_ready_i,
    input  pop_req_o, sel_o, out_valid_o
  );

  modport slave (
    input  valid_i, dest_x_i, dest_y_i, tail_i, out_ready_i,
    output pop_req_o, sel_o, out_valid_o
  );

endinterface
`default_nettype wire

// File: rtl/switch_allocator_rr_arbiter5.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter5
// Description : Five-input round-robin arbiter for one output port. Winner is
//               combinational; the pointer advances to the winner on a grant.
//   clk, rst   : clock, asynchronous active-low reset
//   req_i      : per-input request for this output
//   tail_i     : per-input tail flag of the head flit
//   ready_i    : output can accept a flit this cycle
//   gnt_idx_o  : winning input index
//   gnt_vld_o  : a grant is made this cycle
// Optional    : SWITCH_ALLOC_WORMHOLE_LOCK_EN adds a per-output packet lock.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter5
  import noc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] tail_i,
  input  logic                 ready_i,
  output port_t                gnt_idx_o,
  output logic                 gnt_vld_o
);

  port_t ptr_q, ptr_d;
  port_t w_rr_idx;
  logic  w_rr_vld;

  // Scan from the far end so the nearest requester after ptr_q is the last write.
  always_comb begin
    w_rr_idx = ptr_q;
    w_rr_vld = 1'b0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (req_i[rr_next(ptr_q, k)]) begin
        w_rr_idx = rr_next(ptr_q, k);
        w_rr_vld = 1'b1;
      end
    end
  end

`ifdef SWITCH_ALLOC_WORMHOLE_LOCK_EN
  logic  lock_q, lock_d;
  port_t lk_idx_q, lk_idx_d;

  always_comb begin
    ptr_d    = ptr_q;
    lock_d   = lock_q;
    lk_idx_d = lk_idx_q;
    if (lock_q) begin
      // Mid-packet: only the owning input may use this output.
      gnt_idx_o = lk_idx_q;
      gnt_vld_o = ready_i & req_i[lk_idx_q];
      if (gnt_vld_o && tail_i[lk_idx_q]) begin
        lock_d = 1'b0;
        ptr_d  = lk_idx_q;
      end
    end else begin
      gnt_idx_o = w_rr_idx;
      gnt_vld_o = ready_i & w_rr_vld;
      if (gnt_vld_o) begin
        ptr_d = w_rr_idx;
        if (!tail_i[w_rr_idx]) begin
          lock_d   = 1'b1;
          lk_idx_d = w_rr_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= PORT_L;
      lock_q   <= 1'b0;
      lk_idx_q <= PORT_N;
    end else begin
      ptr_q    <= ptr_d;
      lock_q   <= lock_d;
      lk_idx_q <= lk_idx_d;
    end
  end
`else
  logic w_unused_tail;
  assign w_unused_tail = ^tail_i;

  assign gnt_idx_o = w_rr_idx;
  assign gnt_vld_o = ready_i & w_rr_vld;
  assign ptr_d     = gnt_vld_o ? w_rr_idx : ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= PORT_L;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator
// Description : XY-routed switch allocator for a 5-port router. Routes each
//               queue head, arbitrates per output round-robin and issues
//               registered pop strobes and crossbar select/valid.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : switch_allocator_if.slave (queue heads, readies, pops, selects)
// Optional    : SWITCH_ALLOC_WORMHOLE_LOCK_EN holds an output for a whole
//               packet until its tail flit is granted.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator
  import noc_pkg::*;
#(
  parameter int COORD_W = 2,
  parameter int X_ADDR  = 0,
  parameter int Y_ADDR  = 0
)(
  input  logic               clk,
  input  logic               rst,
  switch_allocator_if.slave  bus
);

  localparam logic [COORD_W-1:0] c_x_addr = COORD_W'(X_ADDR);
  localparam logic [COORD_W-1:0] c_y_addr = COORD_W'(Y_ADDR);

  logic [NUM_PORTS-1:0]  pop_q, pop_d;
  logic [NUM_PORTS-1:0]  vld_q, vld_d;
  port_t [NUM_PORTS-1:0] sel_q, sel_d;

  port_t                 w_route [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_req   [NUM_PORTS];
  port_t                 w_gnt_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_gnt_vld;

  // Dimension-ordered route: resolve X first, then Y, else deliver locally.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_route[p] = PORT_L;
      if (bus.dest_x_i[p*COORD_W +: COORD_W] > c_x_addr)
        w_route[p] = PORT_E;
      else if (bus.dest_x_i[p*COORD_W +: COORD_W] < c_x_addr)
        w_route[p] = PORT_W;
      else if (bus.dest_y_i[p*COORD_W +: COORD_W] > c_y_addr)
        w_route[p] = PORT_N;
      else if (bus.dest_y_i[p*COORD_W +: COORD_W] < c_y_addr)
        w_route[p] = PORT_S;
    end
  end

  // A just-popped input is masked: its queue head still shows the old flit.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        w_req[o][p] = bus.valid_i[p] & ~pop_q[p] & (w_route[p] == port_t'(o));
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter5 u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (w_req[o]),
      .tail_i    (bus.tail_i),
      .ready_i   (bus.out_ready_i[o]),
      .gnt_idx_o (w_gnt_idx[o]),
      .gnt_vld_o (w_gnt_vld[o])
    );
  end

  // Each input routes to one output, so pops from different outputs never collide.
  always_comb begin
    pop_d = '0;
    vld_d = w_gnt_vld;
    sel_d = sel_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (w_gnt_vld[o]) begin
        pop_d[w_gnt_idx[o]] = 1'b1;
        sel_d[o]            = w_gnt_idx[o];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_q <= '0;
      vld_q <= '0;
      sel_q <= '0;
    end else begin
      pop_q <= pop_d;
      vld_q <= vld_d;
      sel_q <= sel_d;
    end
  end

  assign bus.pop_req_o   = pop_q;
  assign bus.out_valid_o = vld_q;
  assign bus.sel_o       = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_allocator
// Description : Self-checking bench for switch_allocator at router (1,1).
//               Directed vector table, reset and packet-lock sequences, then
//               random traffic against a behavioural allocation model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;
  import noc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  switch_allocator_if #(.COORD_W(2)) bus ();

  switch_allocator #(.COORD_W(2), .X_ADDR(1), .Y_ADDR(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(string tag, logic [4:0] pop, logic [4:0] vld, logic [14:0] sel);
    chk({tag, " pop"}, 32'(bus.pop_req_o), 32'(pop));
    chk({tag, " vld"}, 32'(bus.out_valid_o), 32'(vld));
    chk({tag, " sel"}, 32'(bus.sel_o), 32'(sel));
  endtask

  function automatic logic [9:0] d5(int a0, int a1, int a2, int a3, int a4);
    return {2'(a4), 2'(a3), 2'(a2), 2'(a1), 2'(a0)};
  endfunction

  task automatic drive(logic [4:0] v, logic [9:0] dx, logic [9:0] dy,
                       logic [4:0] t, logic [4:0] r);
    bus.valid_i     = v;
    bus.dest_x_i    = dx;
    bus.dest_y_i    = dy;
    bus.tail_i      = t;
    bus.out_ready_i = r;
  endtask

  typedef struct {
    logic [4:0]  valid;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [4:0]  tail;
    logic [4:0]  ready;
    logic [4:0]  pop;
    logic [4:0]  vld;
    logic [14:0] sel;
  } vec_t;

  vec_t tbl[12];

  // ---------------- behavioural model (router at X=1, Y=1) ----------------
  int         m_ptr[5];
  bit         m_lock[5];
  int         m_lk[5];
  int         m_sel[5];
  logic [4:0] m_pop;
  logic [4:0] m_vld;

  function automatic int route_of(int dx, int dy);
    if (dx > 1) return 2;
    if (dx < 1) return 3;
    if (dy > 1) return 0;
    if (dy < 1) return 1;
    return 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_ptr[i] = 4; m_lock[i] = 0; m_lk[i] = 0; m_sel[i] = 0;
    end
    m_pop = '0;
    m_vld = '0;
  endtask

  function automatic bit wants(int p, int o);
    int dx, dy;
    dx = int'(bus.dest_x_i[2*p +: 2]);
    dy = int'(bus.dest_y_i[2*p +: 2]);
    return bus.valid_i[p] && !m_pop[p] && route_of(dx, dy) == o;
  endfunction

  task automatic model_step();
    logic [4:0] npop, nvld;
    int win, c;
    npop = '0;
    nvld = '0;
    for (int o = 0; o < 5; o++) begin
      win = -1;
      if (bus.out_ready_i[o]) begin
        if (m_lock[o]) begin
          if (wants(m_lk[o], o)) win = m_lk[o];
        end else begin
          for (int k = 1; k <= 5; k++) begin
            c = (m_ptr[o] + k) % 5;
            if (win < 0 && wants(c, o)) win = c;
          end
        end
      end
      if (win >= 0) begin
        npop[win] = 1'b1;
        nvld[o]   = 1'b1;
        m_sel[o]  = win;
`ifdef SWITCH_ALLOC_WORMHOLE_LOCK_EN
        if (m_lock[o]) begin
          if (bus.tail_i[win]) begin
            m_lock[o] = 0;
            m_ptr[o]  = win;
          end
        end else begin
          m_ptr[o] = win;
          if (!bus.tail_i[win]) begin
            m_lock[o] = 1;
            m_lk[o]   = win;
          end
        end
`else
        m_ptr[o] = win;
`endif
      end
    end
    m_pop = npop;
    m_vld = nvld;
  endtask

  function automatic logic [14:0] model_sel();
    logic [14:0] s;
    s = '0;
    for (int o = 0; o < 5; o++) s[3*o +: 3] = 3'(m_sel[o]);
    return s;
  endfunction

  // ------------------------------------------------------------------------
  logic [4:0]  hs_pop [6];
  logic [14:0] hs_sel [6];

  initial begin
    // Directed vectors; each row is held for one cycle and checked after the edge.
    tbl[0]  = '{5'b10000, d5(0,0,0,0,2), d5(0,0,0,0,1), 5'h1f, 5'h1f, 5'b10000, 5'b00100, 15'h100};
    tbl[1]  = '{5'b10000, d5(0,0,0,0,2), d5(0,0,0,0,1), 5'h1f, 5'h1f, 5'b00000, 5'b00000, 15'h100};
    tbl[2]  = '{5'b10000, d5(0,0,0,0,2), d5(0,0,0,0,1), 5'h1f, 5'h1f, 5'b10000, 5'b00100, 15'h100};
    tbl[3]  = '{5'b01011, d5(2,2,0,2,0), d5(0,0,0,0,0), 5'h1f, 5'h1f, 5'b00001, 5'b00100, 15'h000};
    tbl[4]  = '{5'b01011, d5(2,2,0,2,0), d5(0,0,0,0,0), 5'h1f, 5'h1f, 5'b00010, 5'b00100, 15'h040};
    tbl[5]  = '{5'b01011, d5(2,2,0,2,0), d5(0,0,0,0,0), 5'h1f, 5'h1f, 5'b01000, 5'b00100, 15'h0c0};
    tbl[6]  = '{5'b01011, d5(2,2,0,2,0), d5(0,0,0,0,0), 5'h1f, 5'h1f, 5'b00001, 5'b00100, 15'h000};
    tbl[7]  = '{5'b01011, d5(2,2,0,2,0), d5(0,0,0,0,0), 5'h1f, 5'h1b, 5'b00000, 5'b00000, 15'h000};
    tbl[8]  = '{5'b01011, d5(2,2,0,2,0), d5(0,0,0,0,0), 5'h1f, 5'h1b, 5'b00000, 5'b00000, 15'h000};
    tbl[9]  = '{5'b01011, d5(2,2,0,2,0), d5(0,0,0,0,0), 5'h1f, 5'h1b, 5'b00000, 5'b00000, 15'h000};
    tbl[10] = '{5'b01011, d5(2,2,0,2,0), d5(0,0,0,0,0), 5'h1f, 5'h1f, 5'b00010, 5'b00100, 15'h040};
    tbl[11] = '{5'b00101, d5(1,0,0,0,0), d5(1,0,1,0,0), 5'h1f, 5'h1f, 5'b00101, 5'b11000, 15'h440};

`ifdef SWITCH_ALLOC_WORMHOLE_LOCK_EN
    hs_pop = '{5'b00001, 5'b00000, 5'b00001, 5'b00000, 5'b00001, 5'b00010};
    hs_sel = '{15'h400, 15'h400, 15'h400, 15'h400, 15'h400, 15'h440};
`else
    hs_pop = '{5'b00001, 5'b00010, 5'b00001, 5'b00010, 5'b00001, 5'b00010};
    hs_sel = '{15'h400, 15'h440, 15'h400, 15'h440, 15'h400, 15'h440};
`endif

    // Reset held with every queue requesting local delivery.
    rst = 1'b0;
    drive(5'h1f, d5(1,1,1,1,1), d5(1,1,1,1,1), 5'h1f, 5'h1f);
    repeat (3) @(posedge clk);
    #1 chk_out("reset_hold", 5'b0, 5'b0, 15'h0);
    rst = 1'b1;
    #1 chk_out("reset_release", 5'b0, 5'b0, 15'h0);
    @(posedge clk); #1;
    chk_out("first_grant", 5'b00001, 5'b10000, 15'h0);
    @(posedge clk); #1;
    chk_out("second_grant", 5'b00010, 5'b10000, 15'h1000);

    // Asynchronous reset in the middle of traffic.
    #2 rst = 1'b0;
    #1 chk_out("async_reset", 5'b0, 5'b0, 15'h0);
    @(posedge clk); #1;
    drive(5'b0, '0, '0, 5'h1f, 5'h1f);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_out("idle_after_reset", 5'b0, 5'b0, 15'h0);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].valid, tbl[i].dx, tbl[i].dy, tbl[i].tail, tbl[i].ready);
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", i), tbl[i].pop, tbl[i].vld, tbl[i].sel);
    end

    // Packet of N toward E competing with single-flit S toward E.
    drive(5'b0, '0, '0, 5'h1f, 5'h1f);
    @(posedge clk); #1;
    chk_out("hs_idle", 5'b0, 5'b0, 15'h440);
    for (int c = 0; c < 6; c++) begin
      drive(5'b00011, d5(2,2,0,0,0), d5(1,1,0,0,0), (c >= 3) ? 5'b00011 : 5'b00010, 5'h1f);
      @(posedge clk); #1;
      chk_out($sformatf("pkt%0d", c), hs_pop[c], (hs_pop[c] != 0) ? 5'b00100 : 5'b0, hs_sel[c]);
    end

    // Random traffic against the model, from a fresh reset.
    rst = 1'b0;
    drive(5'b0, '0, '0, 5'h1f, 5'h1f);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      drive(5'($urandom), 10'($urandom), 10'($urandom),
            5'($urandom | $urandom), 5'($urandom | $urandom));
      model_step();
      @(posedge clk); #1;
      chk_out($sformatf("rnd%0d", n), m_pop, m_vld, model_sel());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
